// File: rtl/register_file_controller_pkg.sv
// Shared constants and FSM encoding for the UART-to-register-file command controller.
package register_file_controller_pkg;

    localparam logic [7:0] CMD_WRITE  = 8'hAA;
    localparam logic [7:0] CMD_READ   = 8'hBB;
    localparam logic [7:0] ERROR_BYTE = 8'hEE;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        RD_ADDR = 3'd3,
        RD_WAIT = 3'd4,
        TX_SEND = 3'd5
    } state_t;

endpackage

// File: rtl/register_file_controller.sv
// Decodes byte-serial write/read frames into register-file accesses; read data returns as one tx byte.
// Optional read watchdog enabled by defining READ_TIMEOUT_EN.
module register_file_controller
    import register_file_controller_pkg::*;
#(
    parameter int DATA_WIDTH          = 8,
    parameter int REGISTER_FILE_DEPTH = 16,
    parameter int TIMEOUT_CYCLES      = 8,
    localparam int ADDR_WIDTH         = $clog2(REGISTER_FILE_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_data_valid,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  write_enable,
    output logic                  read_enable,
    output logic [DATA_WIDTH-1:0] write_data,
    input  logic [DATA_WIDTH-1:0] read_data,
    input  logic                  read_data_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_data_valid,
    input  logic                  tx_busy,
    output logic                  cmd_error
);

    // One extra bit so a depth equal to 2**DATA_WIDTH still compares correctly.
    localparam logic [DATA_WIDTH:0] DEPTH_LIMIT = (DATA_WIDTH+1)'(REGISTER_FILE_DEPTH);

    state_t                state, state_d;
    logic [ADDR_WIDTH-1:0] address_d;
    logic [DATA_WIDTH-1:0] write_data_d, tx_data_d;
    logic                  write_enable_d, read_enable_d, tx_data_valid_d, cmd_error_d;
    logic                  addr_in_range;

    assign addr_in_range = ({1'b0, rx_data} < DEPTH_LIMIT);

`ifdef READ_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TIMER_W-1:0] timer, timer_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0) ^ (ERROR_BYTE == 8'h00);
`endif

    always_comb begin
        // NOTE: every variable gets a default before the case; a path that skips one would infer a latch.
        state_d         = state;
        address_d       = address;
        write_data_d    = write_data;
        tx_data_d       = tx_data;
        write_enable_d  = 1'b0;
        read_enable_d   = 1'b0;
        tx_data_valid_d = 1'b0;
        cmd_error_d     = 1'b0;
`ifdef READ_TIMEOUT_EN
        timer_d         = timer;
`endif
        case (state)
            IDLE: if (rx_data_valid) begin
                if (rx_data == DATA_WIDTH'(CMD_WRITE))     state_d = WR_ADDR;
                else if (rx_data == DATA_WIDTH'(CMD_READ)) state_d = RD_ADDR;
                else                                       cmd_error_d = 1'b1;
            end
            WR_ADDR: if (rx_data_valid) begin
                if (addr_in_range) begin
                    address_d = rx_data[ADDR_WIDTH-1:0];
                    state_d   = WR_DATA;
                end else begin
                    cmd_error_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            WR_DATA: if (rx_data_valid) begin
                write_data_d   = rx_data;
                write_enable_d = 1'b1;
                state_d        = IDLE;
            end
            RD_ADDR: if (rx_data_valid) begin
                if (addr_in_range) begin
                    address_d     = rx_data[ADDR_WIDTH-1:0];
                    read_enable_d = 1'b1;
                    state_d       = RD_WAIT;
`ifdef READ_TIMEOUT_EN
                    timer_d       = '0;
`endif
                end else begin
                    cmd_error_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            // The first RD_WAIT cycle is the read_enable cycle, so a same-cycle response is captured.
            RD_WAIT: begin
                if (read_data_valid) begin
                    tx_data_d = read_data;
                    state_d   = TX_SEND;
                end
`ifdef READ_TIMEOUT_EN
                else if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                    tx_data_d   = DATA_WIDTH'(ERROR_BYTE);
                    cmd_error_d = 1'b1;
                    state_d     = TX_SEND;
                end else begin
                    timer_d = timer + 1'b1;
                end
`endif
            end
            TX_SEND: if (!tx_busy) begin
                tx_data_valid_d = 1'b1;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            address       <= '0;
            write_data    <= '0;
            tx_data       <= '0;
            write_enable  <= 1'b0;
            read_enable   <= 1'b0;
            tx_data_valid <= 1'b0;
            cmd_error     <= 1'b0;
        end else begin
            address       <= address_d;
            write_data    <= write_data_d;
            tx_data       <= tx_data_d;
            write_enable  <= write_enable_d;
            read_enable   <= read_enable_d;
            tx_data_valid <= tx_data_valid_d;
            cmd_error     <= cmd_error_d;
        end
    end

`ifdef READ_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer <= '0;
        end else begin
            timer <= timer_d;
        end
    end
`endif

endmodule

// File: tb/tb_register_file_controller.sv
// Self-checking bench: table-driven frames plus hand sequences, with an event scoreboard queue.
module tb_register_file_controller;

    typedef enum int {EV_WRITE = 0, EV_READ = 1, EV_TX = 2, EV_ERR = 3} ev_kind_t;

    typedef struct {
        ev_kind_t kind;
        int       addr;
        int       data;
        int       cyc;
    } ev_t;

    typedef struct {
        logic [7:0] b0, b1, b2;
        int         n;
        ev_kind_t   kind;   // EV_READ means read strobe followed by a tx byte
        int         addr;
        int         data;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_data_valid = 1'b0;
    logic [3:0] address;
    logic       write_enable, read_enable;
    logic [7:0] write_data;
    logic [7:0] read_data = '0;
    logic       read_data_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_busy = 1'b0;
    logic       cmd_error;

    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    int  tx_count = 0;
    bit  rf_respond = 1'b1;
    logic [7:0] rf [16];
    ev_t exp_q [$];
    vec_t vecs [11];

    register_file_controller dut (
        .clk            (clk),
        .reset          (rst_n),
        .rx_data        (rx_data),
        .rx_data_valid  (rx_data_valid),
        .address        (address),
        .write_enable   (write_enable),
        .read_enable    (read_enable),
        .write_data     (write_data),
        .read_data      (read_data),
        .read_data_valid(read_data_valid),
        .tx_data        (tx_data),
        .tx_data_valid  (tx_data_valid),
        .tx_busy        (tx_busy),
        .cmd_error      (cmd_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int all_outputs();
        return int'({address, write_enable, read_enable, write_data, tx_data, tx_data_valid, cmd_error});
    endfunction

    task automatic push(input ev_kind_t kind, input int addr, input int data, input int c);
        ev_t e;
        e.kind = kind; e.addr = addr; e.data = data; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_kind_t kind, input int addr, input int data);
        ev_t e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected no event", int'(kind), cyc);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", int'(kind), int'(e.kind));
            if (kind == e.kind) begin
                if (kind == EV_WRITE || kind == EV_READ) check("event_addr", addr, e.addr);
                if (kind == EV_WRITE || kind == EV_TX)   check("event_data", data, e.data);
                if (e.cyc >= 0)                          check("event_cycle", cyc, e.cyc);
            end
        end
    endtask

    // Output monitor and register-file model; the model answers in the read_enable cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_error)    observe(EV_ERR, 0, 0);
            if (write_enable) begin
                observe(EV_WRITE, int'(address), int'(write_data));
                rf[address] = write_data;
            end
            if (read_enable)  observe(EV_READ, int'(address), 0);
            if (tx_data_valid) begin
                observe(EV_TX, 0, int'(tx_data));
                tx_count++;
            end
            if (write_enable && read_enable) check("enables_exclusive", 1, 0);
        end
        if (rf_respond && read_enable) begin
            read_data       = rf[address];
            read_data_valid = 1'b1;
        end else begin
            read_data_valid = 1'b0;
        end
    end

    // Called at a negedge; leaves at the next negedge with the strobe dropped.
    task automatic send_byte(input logic [7:0] b);
        rx_data       = b;
        rx_data_valid = 1'b1;
        @(negedge clk);
        rx_data_valid = 1'b0;
    endtask

    task automatic send_frame(input vec_t v);
        for (int i = 0; i < v.n; i++) begin
            if (i == v.n - 1) begin
                case (v.kind)
                    EV_WRITE: push(EV_WRITE, v.addr, v.data, cyc + 1);
                    EV_READ: begin
                        push(EV_READ, v.addr, 0, cyc + 1);
                        push(EV_TX, 0, v.data, cyc + 3);
                    end
                    default: push(EV_ERR, 0, 0, cyc + 1);
                endcase
            end
            send_byte(i == 0 ? v.b0 : (i == 1 ? v.b1 : v.b2));
        end
    endtask

    task automatic wait_drain(input int bound);
        for (int i = 0; i < bound && exp_q.size() != 0; i++) @(negedge clk);
        check("events_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int k, busy_start, fall, tx_before;
        vec_t v;
        foreach (rf[i]) rf[i] = '0;

        vecs[0]  = '{8'hAA, 8'h0E, 8'hF4, 3, EV_WRITE, 14, 8'hF4};
        vecs[1]  = '{8'hBB, 8'h0E, 8'h00, 2, EV_READ,  14, 8'hF4};
        vecs[2]  = '{8'h11, 8'h00, 8'h00, 1, EV_ERR,    0, 0};
        vecs[3]  = '{8'hAA, 8'h10, 8'h00, 2, EV_ERR,    0, 0};
        vecs[4]  = '{8'hAA, 8'h01, 8'h7E, 3, EV_WRITE,  1, 8'h7E};
        vecs[5]  = '{8'hBB, 8'h01, 8'h00, 2, EV_READ,   1, 8'h7E};
        vecs[6]  = '{8'hAA, 8'h05, 8'hC3, 3, EV_WRITE,  5, 8'hC3};
        vecs[7]  = '{8'hAA, 8'h0F, 8'hA5, 3, EV_WRITE, 15, 8'hA5};
        vecs[8]  = '{8'hBB, 8'h0F, 8'h00, 2, EV_READ,  15, 8'hA5};
        vecs[9]  = '{8'hBB, 8'hFF, 8'h00, 2, EV_ERR,    0, 0};
        vecs[10] = '{8'hBB, 8'h05, 8'h00, 2, EV_READ,   5, 8'hC3};

        repeat (3) @(negedge clk);
        check("reset_outputs", all_outputs(), 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            send_frame(vecs[i]);
            repeat (2) @(negedge clk);
            wait_drain(20);
        end

        // Reset in the middle of a write frame discards it; a fresh frame then works.
        send_byte(8'hAA);
        rst_n = 1'b0;
        #1;
        check("midframe_reset_outputs", all_outputs(), 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        v = '{8'hAA, 8'h03, 8'h5C, 3, EV_WRITE, 3, 8'h5C};
        send_frame(v);
        wait_drain(20);

        // Write immediately followed by a read of the same register, no idle gap.
        v = '{8'hAA, 8'h02, 8'h33, 3, EV_WRITE, 2, 8'h33};
        send_frame(v);
        v = '{8'hBB, 8'h02, 8'h00, 2, EV_READ, 2, 8'h33};
        send_frame(v);
        wait_drain(20);

        // Transmitter busy: response held until tx_busy drops, extra rx bytes dropped.
        tx_busy    = 1'b1;
        busy_start = cyc;
        send_byte(8'hBB);
        push(EV_READ, 5, 0, cyc + 1);
        send_byte(8'h05);
        repeat (3) @(negedge clk);
        send_byte(8'hAA);
        send_byte(8'hFF);
        while (cyc < busy_start + 10) @(negedge clk);
        tx_busy = 1'b0;
        fall    = cyc;
        push(EV_TX, 0, 8'hC3, fall + 1);
        wait_drain(10);

`ifdef READ_TIMEOUT_EN
        // No read response: error byte after the timeout window plus a cmd_error pulse.
        rf_respond = 1'b0;
        send_byte(8'hBB);
        k = cyc;
        push(EV_READ, 4, 0, k + 1);
        push(EV_ERR, 0, 0, k + 9);
        push(EV_TX, 0, 8'hEE, k + 10);
        send_byte(8'h04);
        wait_drain(30);
        rf_respond = 1'b1;
        v = '{8'hBB, 8'h01, 8'h00, 2, EV_READ, 1, 8'h7E};
        send_frame(v);
        wait_drain(20);
`else
        // Without the watchdog a missing response leaves the controller waiting.
        rf_respond = 1'b0;
        tx_before  = tx_count;
        send_byte(8'hBB);
        k = cyc;
        push(EV_READ, 4, 0, k + 1);
        send_byte(8'h04);
        repeat (100) @(negedge clk);
        check("no_response_without_timeout", tx_count - tx_before, 0);
        wait_drain(1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rf_respond = 1'b1;
        @(negedge clk);
        v = '{8'hBB, 8'h01, 8'h00, 2, EV_READ, 1, 8'h7E};
        send_frame(v);
        wait_drain(20);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
